ctrl_pipeline: RTL and testbench
================================

Name: ctrl_pipeline

Overview:
- Control-path pipeline and hazard unit for the 5-stage MIPS core.
- Sits directly downstream of the decode-stage controller. Consumes its per-instruction control word plus register specifiers from the D stage.
- Carries control through the E, M and W pipeline registers.
- Generates stall, flush and forwarding selects for the datapath.
- Branches resolve in D.

Parameters:
CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d, branch_d, jump_d  input  1 each  D-stage controls from controller
alucontrol_d  input  3  D-stage ALU op from controller
rs_d, rt_d, rd_d  input  5 each  D-stage register specifiers
equal_d  input  1  datapath compare of forwarded D operands
regwrite_e, memtoreg_e, memwrite_e, alusrc_e  output  1 each  E-stage controls
alucontrol_e  output  3  E-stage ALU op
rs_e, rt_e  output  5 each  E-stage specifiers
writereg_e, writereg_m, writereg_w  output  5 each  destination register per stage
regwrite_m, memtoreg_m, memwrite_m  output  1 each  M-stage controls
regwrite_w, memtoreg_w  output  1 each  W-stage controls
pcsrc_d  output  1  branch taken
stall_f, stall_d  output  1 each  hold PC / IF-ID register
flush_d  output  1  clear IF-ID register
flush_e  output  1  (informational) E stage loaded bubble this edge
forward_a_d, forward_b_d  output  1 each  D-operand forward from M ALU result
forward_a_e, forward_b_e  output  2 each  00 regfile, 10 M ALU result, 01 W result
stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset, synchronous: every registered output goes to 0 on the first edge with reset=1. This covers all E/M/W controls, specifiers, writereg_* and stall_count.
- E register: rd_e is internal. writereg_e = regdst_e ? rd_e : rt_e (combinational).
- Pipeline advance, each edge:
  - E loads D inputs, or all-zero when flush_e=1. Zero loading overrides X on the D inputs.
  - M loads E.
  - W loads M.
- M and W never stall or flush.
- One-cycle latency per stage. regwrite_d reaches regwrite_w three edges later.
- lwstall = memtoreg_e & (rt_e!=0) & (rt_e==rs_d | rt_e==rt_d).
- branchstall = branch_d & [ (regwrite_e & writereg_e!=0 & writereg_e∈{rs_d,rt_d}) | (memtoreg_m & writereg_m!=0 & writereg_m∈{rs_d,rt_d}) ].
- stall_f = stall_d = flush_e = lwstall | branchstall (combinational).
- pcsrc_d = branch_d & equal_d.
- flush_d = (pcsrc_d | jump_d) & ~stall_d. A stalled branch never flushes.
- forward_a_e:
  - 10 if regwrite_m & writereg_m!=0 & writereg_m==rs_e.
  - Else 01 if regwrite_w & writereg_w!=0 & writereg_w==rs_e.
  - Else 00. M has priority over W.
- forward_b_e: same rules using rt_e.
- forward_a_d = regwrite_m & writereg_m!=0 & writereg_m==rs_d.
- forward_b_d: same rules using rt_d.
- Register $0 never forwards and never stalls.
- stall_count: increments on each edge with stall_d=1. Holds at all-ones. Never wraps.
- Reset during a stall:
  - All registers clear.
  - Stalls deassert the next cycle, since E/M hold zeros.
  - Count returns to 0.
- Simultaneous lwstall and branchstall produce a single stall cycle and a single count increment.

Test Plan:
- Reset held 2 cycles -> all outputs 0 and stall_count=0. After release with all-zero D inputs, outputs stay 0.
- add $8 (rd=8, regdst=1, regwrite=1), then add $9,$8,$10 -> when the second add is in E: forward_a_e=10. One cycle later, in M-distance case: forward_a_e=01. No stall at any point.
- lw $9 (memtoreg=1, rt=9), then add using rs_d=9:
  - One cycle with stall_f=stall_d=flush_e=1.
  - Next cycle regwrite_e=0 (bubble), then forward_a_e=01.
  - stall_count=1.
- add $8, then beq $8,$0 with equal_d=1:
  - One branchstall cycle with flush_d=0.
  - Next cycle forward_a_d=1, pcsrc_d=1, flush_d=1.
- Writes to $0 (rd=0) followed by a reader of $0 -> forward selects stay 00/0 and no stall. Same with lw rt=0.
- Hold a lwstall condition, then assert reset mid-stall -> next cycle all outputs 0 and stall_count=0. With CNT_W=4 and 20 forced stalls, stall_count saturates at 15.

Source files
------------

// File: rtl/ctrl_pipeline.sv
// ============================================================================
// Module   : ctrl_pipeline
// Brief    : Control-path E/M/W pipeline registers plus hazard unit
//            (stall, flush and forwarding selects) for a 5-stage MIPS core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_pipeline #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             regwrite_d,
    input  logic             memtoreg_d,
    input  logic             memwrite_d,
    input  logic             alusrc_d,
    input  logic             regdst_d,
    input  logic             branch_d,
    input  logic             jump_d,
    input  logic [2:0]       alucontrol_d,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic [4:0]       rd_d,
    input  logic             equal_d,
    output logic             regwrite_e,
    output logic             memtoreg_e,
    output logic             memwrite_e,
    output logic             alusrc_e,
    output logic [2:0]       alucontrol_e,
    output logic [4:0]       rs_e,
    output logic [4:0]       rt_e,
    output logic [4:0]       writereg_e,
    output logic [4:0]       writereg_m,
    output logic [4:0]       writereg_w,
    output logic             regwrite_m,
    output logic             memtoreg_m,
    output logic             memwrite_m,
    output logic             regwrite_w,
    output logic             memtoreg_w,
    output logic             pcsrc_d,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             forward_a_d,
    output logic             forward_b_d,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic [CNT_W-1:0] stall_count
);

    logic             r_regwrite_e;
    logic             r_memtoreg_e;
    logic             r_memwrite_e;
    logic             r_alusrc_e;
    logic             r_regdst_e;
    logic [2:0]       r_alucontrol_e;
    logic [4:0]       r_rs_e;
    logic [4:0]       r_rt_e;
    logic [4:0]       r_rd_e;
    logic             r_regwrite_m;
    logic             r_memtoreg_m;
    logic             r_memwrite_m;
    logic [4:0]       r_writereg_m;
    logic             r_regwrite_w;
    logic             r_memtoreg_w;
    logic [4:0]       r_writereg_w;
    logic [CNT_W-1:0] r_stall_count;

    logic             w_writereg_e;
    logic [4:0]       w_wreg_e;
    logic             w_lwstall;
    logic             w_br_e_hit;
    logic             w_br_m_hit;
    logic             w_branchstall;
    logic             w_stall;
    logic             w_pcsrc;

    // writereg_e is a mux, not a register, so it tracks rd_e/rt_e directly
    assign w_wreg_e     = r_regdst_e ? r_rd_e : r_rt_e;
    assign w_writereg_e = (w_wreg_e != 5'd0);

    assign w_lwstall    = r_memtoreg_e && (r_rt_e != 5'd0) &&
                          ((r_rt_e == rs_d) || (r_rt_e == rt_d));
    assign w_br_e_hit   = r_regwrite_e && w_writereg_e &&
                          ((w_wreg_e == rs_d) || (w_wreg_e == rt_d));
    assign w_br_m_hit   = r_memtoreg_m && (r_writereg_m != 5'd0) &&
                          ((r_writereg_m == rs_d) || (r_writereg_m == rt_d));
    assign w_branchstall = branch_d && (w_br_e_hit || w_br_m_hit);
    assign w_stall       = w_lwstall || w_branchstall;
    assign w_pcsrc       = branch_d && equal_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regwrite_e   <= 1'b0;
            r_memtoreg_e   <= 1'b0;
            r_memwrite_e   <= 1'b0;
            r_alusrc_e     <= 1'b0;
            r_regdst_e     <= 1'b0;
            r_alucontrol_e <= 3'd0;
            r_rs_e         <= 5'd0;
            r_rt_e         <= 5'd0;
            r_rd_e         <= 5'd0;
            r_regwrite_m   <= 1'b0;
            r_memtoreg_m   <= 1'b0;
            r_memwrite_m   <= 1'b0;
            r_writereg_m   <= 5'd0;
            r_regwrite_w   <= 1'b0;
            r_memtoreg_w   <= 1'b0;
            r_writereg_w   <= 5'd0;
            r_stall_count  <= '0;
        end else begin
            // A stalled instruction stays in D, so E takes a clean bubble
            if (w_stall) begin
                r_regwrite_e   <= 1'b0;
                r_memtoreg_e   <= 1'b0;
                r_memwrite_e   <= 1'b0;
                r_alusrc_e     <= 1'b0;
                r_regdst_e     <= 1'b0;
                r_alucontrol_e <= 3'd0;
                r_rs_e         <= 5'd0;
                r_rt_e         <= 5'd0;
                r_rd_e         <= 5'd0;
            end else begin
                r_regwrite_e   <= regwrite_d;
                r_memtoreg_e   <= memtoreg_d;
                r_memwrite_e   <= memwrite_d;
                r_alusrc_e     <= alusrc_d;
                r_regdst_e     <= regdst_d;
                r_alucontrol_e <= alucontrol_d;
                r_rs_e         <= rs_d;
                r_rt_e         <= rt_d;
                r_rd_e         <= rd_d;
            end
            r_regwrite_m <= r_regwrite_e;
            r_memtoreg_m <= r_memtoreg_e;
            r_memwrite_m <= r_memwrite_e;
            r_writereg_m <= w_wreg_e;
            r_regwrite_w <= r_regwrite_m;
            r_memtoreg_w <= r_memtoreg_m;
            r_writereg_w <= r_writereg_m;
            if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        forward_a_e = 2'b00;
        if (r_regwrite_m && (r_writereg_m != 5'd0) && (r_writereg_m == r_rs_e)) begin
            forward_a_e = 2'b10;
        end else if (r_regwrite_w && (r_writereg_w != 5'd0) && (r_writereg_w == r_rs_e)) begin
            forward_a_e = 2'b01;
        end
    end

    always_comb begin
        forward_b_e = 2'b00;
        if (r_regwrite_m && (r_writereg_m != 5'd0) && (r_writereg_m == r_rt_e)) begin
            forward_b_e = 2'b10;
        end else if (r_regwrite_w && (r_writereg_w != 5'd0) && (r_writereg_w == r_rt_e)) begin
            forward_b_e = 2'b01;
        end
    end

    assign forward_a_d = r_regwrite_m && (r_writereg_m != 5'd0) && (r_writereg_m == rs_d);
    assign forward_b_d = r_regwrite_m && (r_writereg_m != 5'd0) && (r_writereg_m == rt_d);

    assign stall_f = w_stall;
    assign stall_d = w_stall;
    assign flush_e = w_stall;
    assign pcsrc_d = w_pcsrc;
    assign flush_d = (w_pcsrc || jump_d) && !w_stall;

    assign regwrite_e   = r_regwrite_e;
    assign memtoreg_e   = r_memtoreg_e;
    assign memwrite_e   = r_memwrite_e;
    assign alusrc_e     = r_alusrc_e;
    assign alucontrol_e = r_alucontrol_e;
    assign rs_e         = r_rs_e;
    assign rt_e         = r_rt_e;
    assign writereg_e   = w_wreg_e;
    assign regwrite_m   = r_regwrite_m;
    assign memtoreg_m   = r_memtoreg_m;
    assign memwrite_m   = r_memwrite_m;
    assign writereg_m   = r_writereg_m;
    assign regwrite_w   = r_regwrite_w;
    assign memtoreg_w   = r_memtoreg_w;
    assign writereg_w   = r_writereg_w;
    assign stall_count  = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipeline.sv
// ============================================================================
// Module   : tb_ctrl_pipeline
// Brief    : Directed scoreboard bench for ctrl_pipeline (CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_pipeline;

    localparam int C_CNT_W = 4;

    typedef struct packed {
        logic       rw, mtr, mw, asrc, rdst, br, jmp;
        logic [2:0] alu;
        logic [4:0] rs, rt, rd;
        logic       eq;
    } instr_t;

    typedef struct packed {
        logic       rw_e;
        logic [4:0] wr_e, rs_e, rt_e;
        logic       rw_m;
        logic [4:0] wr_m;
        logic       rw_w;
        logic [4:0] wr_w;
        logic [1:0] fa_e, fb_e;
        logic       fa_d, fb_d, st, fl, pc;
        logic [3:0] cnt;
        logic [8:0] misc;
    } exp_t;

    localparam instr_t NOP   = '0;
    localparam instr_t ADD8  = {7'b1000100, 3'b010, 5'd1, 5'd2,  5'd8,  1'b0};
    localparam instr_t ADD9  = {7'b1000100, 3'b010, 5'd8, 5'd10, 5'd9,  1'b0};
    localparam instr_t SW56  = {7'b0011000, 3'b010, 5'd5, 5'd6,  5'd0,  1'b0};
    localparam instr_t LW9   = {7'b1101000, 3'b010, 5'd3, 5'd9,  5'd0,  1'b0};
    localparam instr_t ADDR9 = {7'b1000100, 3'b010, 5'd9, 5'd4,  5'd11, 1'b0};
    localparam instr_t BEQ8  = {7'b0000010, 3'b110, 5'd8, 5'd0,  5'd0,  1'b1};
    localparam instr_t ADD0  = {7'b1000100, 3'b010, 5'd1, 5'd2,  5'd0,  1'b0};
    localparam instr_t RD0   = {7'b1000100, 3'b010, 5'd0, 5'd0,  5'd12, 1'b0};
    localparam instr_t LW0   = {7'b1101000, 3'b010, 5'd3, 5'd0,  5'd0,  1'b0};
    localparam instr_t BEQ0N = {7'b0000010, 3'b110, 5'd0, 5'd0,  5'd0,  1'b0};
    localparam instr_t BEQ0T = {7'b0000010, 3'b110, 5'd0, 5'd0,  5'd0,  1'b1};
    localparam instr_t BEQ9  = {7'b0000010, 3'b110, 5'd9, 5'd0,  5'd0,  1'b0};
    localparam instr_t JMP   = {7'b0000001, 3'b000, 5'd0, 5'd0,  5'd0,  1'b0};
    localparam instr_t LWSAT = {7'b1101000, 3'b010, 5'd9, 5'd9,  5'd0,  1'b0};

    logic clk = 1'b0;
    logic reset;
    logic regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d, branch_d, jump_d;
    logic [2:0] alucontrol_d;
    logic [4:0] rs_d, rt_d, rd_d;
    logic equal_d;
    logic regwrite_e, memtoreg_e, memwrite_e, alusrc_e;
    logic [2:0] alucontrol_e;
    logic [4:0] rs_e, rt_e, writereg_e, writereg_m, writereg_w;
    logic regwrite_m, memtoreg_m, memwrite_m, regwrite_w, memtoreg_w;
    logic pcsrc_d, stall_f, stall_d, flush_d, flush_e, forward_a_d, forward_b_d;
    logic [1:0] forward_a_e, forward_b_e;
    logic [C_CNT_W-1:0] stall_count;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_cyc  = 0;

    always #5 clk = ~clk;

    ctrl_pipeline #(.CNT_W(C_CNT_W)) dut (
        .clk(clk), .reset(reset),
        .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d),
        .alusrc_d(alusrc_d), .regdst_d(regdst_d), .branch_d(branch_d), .jump_d(jump_d),
        .alucontrol_d(alucontrol_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .equal_d(equal_d),
        .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e),
        .alusrc_e(alusrc_e), .alucontrol_e(alucontrol_e), .rs_e(rs_e), .rt_e(rt_e),
        .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
        .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .memwrite_m(memwrite_m),
        .regwrite_w(regwrite_w), .memtoreg_w(memtoreg_w),
        .pcsrc_d(pcsrc_d), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .flush_e(flush_e),
        .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_count(stall_count)
    );

    function automatic exp_t mk(int rw_e, int wr_e, int rs_e_v, int rt_e_v,
                                int rw_m, int wr_m, int rw_w, int wr_w,
                                int fa_e, int fb_e, int fa_d, int fb_d,
                                int st, int fl, int pc, int cnt, int misc);
        exp_t e;
        e.rw_e = 1'(rw_e);   e.wr_e = 5'(wr_e);   e.rs_e = 5'(rs_e_v); e.rt_e = 5'(rt_e_v);
        e.rw_m = 1'(rw_m);   e.wr_m = 5'(wr_m);   e.rw_w = 1'(rw_w);   e.wr_w = 5'(wr_w);
        e.fa_e = 2'(fa_e);   e.fb_e = 2'(fb_e);   e.fa_d = 1'(fa_d);   e.fb_d = 1'(fb_d);
        e.st   = 1'(st);     e.fl   = 1'(fl);     e.pc   = 1'(pc);
        e.cnt  = 4'(cnt);    e.misc = 9'(misc);
        return e;
    endfunction

    function automatic exp_t zr(int cnt);
        return mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, cnt, 0);
    endfunction

    // Apply one D-stage instruction for a cycle and queue what the DUT must show
    task automatic cyc(input instr_t d, input logic rst, input exp_t e);
        @(posedge clk);
        #1;
        reset = rst;
        {regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d, branch_d, jump_d} =
            {d.rw, d.mtr, d.mw, d.asrc, d.rdst, d.br, d.jmp};
        alucontrol_d = d.alu;
        rs_d = d.rs; rt_d = d.rt; rd_d = d.rd; equal_d = d.eq;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cycle %0d %s: got %0h expected %0h", n_cyc, name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            n_cyc++;
            chk("regwrite_e",  32'(regwrite_e),  32'(e.rw_e));
            chk("writereg_e",  32'(writereg_e),  32'(e.wr_e));
            chk("rs_e",        32'(rs_e),        32'(e.rs_e));
            chk("rt_e",        32'(rt_e),        32'(e.rt_e));
            chk("regwrite_m",  32'(regwrite_m),  32'(e.rw_m));
            chk("writereg_m",  32'(writereg_m),  32'(e.wr_m));
            chk("regwrite_w",  32'(regwrite_w),  32'(e.rw_w));
            chk("writereg_w",  32'(writereg_w),  32'(e.wr_w));
            chk("forward_a_e", 32'(forward_a_e), 32'(e.fa_e));
            chk("forward_b_e", 32'(forward_b_e), 32'(e.fb_e));
            chk("forward_a_d", 32'(forward_a_d), 32'(e.fa_d));
            chk("forward_b_d", 32'(forward_b_d), 32'(e.fb_d));
            chk("stall_f",     32'(stall_f),     32'(e.st));
            chk("stall_d",     32'(stall_d),     32'(e.st));
            chk("flush_e",     32'(flush_e),     32'(e.st));
            chk("flush_d",     32'(flush_d),     32'(e.fl));
            chk("pcsrc_d",     32'(pcsrc_d),     32'(e.pc));
            chk("stall_count", 32'(stall_count), 32'(e.cnt));
            chk("misc_ctrl",   32'({memtoreg_e, memwrite_e, alusrc_e, alucontrol_e,
                                    memtoreg_m, memwrite_m, memtoreg_w}), 32'(e.misc));
        end
    end

    initial begin
        reset = 1'b1;
        {regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d, branch_d, jump_d} = '0;
        alucontrol_d = '0; rs_d = '0; rt_d = '0; rd_d = '0; equal_d = 1'b0;
        repeat (2) @(posedge clk);

        // Reset and idle
        cyc(NOP, 1'b1, zr(0));
        cyc(NOP, 1'b0, zr(0));
        cyc(NOP, 1'b0, zr(0));

        // Back-to-back dependent add: M-stage forward
        cyc(ADD8, 1'b0, zr(0));
        cyc(ADD9, 1'b0, mk(1,8,1,2,    0,0,0,0, 0,0,0,0, 0,0,0,0, 9'b000010000));
        cyc(SW56, 1'b0, mk(1,9,8,10,   1,8,0,0, 2,0,0,0, 0,0,0,0, 9'b000010000));
        cyc(NOP,  1'b0, mk(0,6,5,6,    1,9,1,8, 0,0,0,0, 0,0,0,0, 9'b011010000));
        cyc(NOP,  1'b0, mk(0,0,0,0,    0,6,1,9, 0,0,0,0, 0,0,0,0, 9'b000000010));
        cyc(NOP,  1'b0, mk(0,0,0,0,    0,0,0,6, 0,0,0,0, 0,0,0,0, 9'b000000000));

        // One instruction apart: W-stage forward, D-stage forward
        cyc(ADD8, 1'b0, zr(0));
        cyc(NOP,  1'b0, mk(1,8,1,2,    0,0,0,0, 0,0,0,0, 0,0,0,0, 9'b000010000));
        cyc(ADD9, 1'b0, mk(0,0,0,0,    1,8,0,0, 0,0,1,0, 0,0,0,0, 9'b000000000));
        cyc(NOP,  1'b0, mk(1,9,8,10,   0,0,1,8, 1,0,0,0, 0,0,0,0, 9'b000010000));
        cyc(NOP,  1'b0, mk(0,0,0,0,    1,9,0,0, 0,0,0,0, 0,0,0,0, 9'b000000000));
        cyc(NOP,  1'b0, mk(0,0,0,0,    0,0,1,9, 0,0,0,0, 0,0,0,0, 9'b000000000));

        // Load-use stall
        cyc(LW9,   1'b0, zr(0));
        cyc(ADDR9, 1'b0, mk(1,9,3,9,   0,0,0,0, 0,0,0,0, 1,0,0,0, 9'b101010000));
        cyc(ADDR9, 1'b0, mk(0,0,0,0,   1,9,0,0, 0,0,1,0, 0,0,0,1, 9'b000000100));
        cyc(NOP,   1'b0, mk(1,11,9,4,  0,0,1,9, 1,0,0,0, 0,0,0,1, 9'b000010001));
        cyc(NOP,   1'b0, mk(0,0,0,0,   1,11,0,0, 0,0,0,0, 0,0,0,1, 9'b000000000));
        cyc(NOP,   1'b0, mk(0,0,0,0,   0,0,1,11, 0,0,0,0, 0,0,0,1, 9'b000000000));

        // Branch on a result still in E: stall without flush, then taken
        cyc(ADD8, 1'b0, zr(1));
        cyc(BEQ8, 1'b0, mk(1,8,1,2,    0,0,0,0, 0,0,0,0, 1,0,1,1, 9'b000010000));
        cyc(BEQ8, 1'b0, mk(0,0,0,0,    1,8,0,0, 0,0,1,0, 0,1,1,2, 9'b000000000));
        cyc(NOP,  1'b0, mk(0,0,8,0,    0,0,1,8, 1,0,0,0, 0,0,0,2, 9'b000110000));
        cyc(NOP,  1'b0, zr(2));
        cyc(NOP,  1'b0, zr(2));

        // Register $0 never forwards or stalls
        cyc(ADD0,  1'b0, zr(2));
        cyc(RD0,   1'b0, mk(1,0,1,2,   0,0,0,0, 0,0,0,0, 0,0,0,2, 9'b000010000));
        cyc(LW0,   1'b0, mk(1,12,0,0,  1,0,0,0, 0,0,0,0, 0,0,0,2, 9'b000010000));
        cyc(BEQ0N, 1'b0, mk(1,0,3,0,   1,12,1,0, 0,0,0,0, 0,0,0,2, 9'b101010000));
        cyc(BEQ0T, 1'b0, mk(0,0,0,0,   1,0,1,12, 0,0,0,0, 0,1,1,2, 9'b000110100));
        cyc(NOP,   1'b0, mk(0,0,0,0,   0,0,1,0,  0,0,0,0, 0,0,0,2, 9'b000110001));
        cyc(NOP,   1'b0, zr(2));
        cyc(NOP,   1'b0, zr(2));

        // Simultaneous lw/branch stall counts once, then M-stage load stall, then jump
        cyc(LW9,  1'b0, zr(2));
        cyc(BEQ9, 1'b0, mk(1,9,3,9,    0,0,0,0, 0,0,0,0, 1,0,0,2, 9'b101010000));
        cyc(BEQ9, 1'b0, mk(0,0,0,0,    1,9,0,0, 0,0,1,0, 1,0,0,3, 9'b000000100));
        cyc(BEQ9, 1'b0, mk(0,0,0,0,    0,0,1,9, 0,0,0,0, 0,0,0,4, 9'b000000001));
        cyc(JMP,  1'b0, mk(0,0,9,0,    0,0,0,0, 0,0,0,0, 0,1,0,4, 9'b000110000));
        cyc(NOP,  1'b0, zr(4));

        // Reset asserted during a load-use stall
        cyc(LW9,   1'b0, zr(4));
        cyc(ADDR9, 1'b1, mk(1,9,3,9,   0,0,0,0, 0,0,0,0, 1,0,0,4, 9'b101010000));
        cyc(ADDR9, 1'b0, zr(0));
        cyc(NOP,   1'b0, mk(1,11,9,4,  0,0,0,0, 0,0,0,0, 0,0,0,0, 9'b000010000));
        cyc(NOP,   1'b0, mk(0,0,0,0,   1,11,0,0, 0,0,0,0, 0,0,0,0, 9'b000000000));
        cyc(NOP,   1'b0, mk(0,0,0,0,   0,0,1,11, 0,0,0,0, 0,0,0,0, 9'b000000000));

        // 20 stalls into a 4-bit counter: saturates at 15
        cyc(LWSAT, 1'b0, zr(0));
        for (int i = 1; i <= 20; i++) begin
            cyc(LWSAT, 1'b0, mk(1,9,9,9, 0,0, (i > 1) ? 1 : 0, (i > 1) ? 9 : 0,
                                (i > 1) ? 1 : 0, (i > 1) ? 1 : 0, 0,0, 1,0,0,
                                (i - 1 > 15) ? 15 : i - 1,
                                (i > 1) ? 9'b101010001 : 9'b101010000));
            cyc(LWSAT, 1'b0, mk(0,0,0,0, 1,9,0,0, 0,0,1,1, 0,0,0,
                                (i > 15) ? 15 : i, 9'b000000100));
        end
        cyc(NOP, 1'b0, mk(1,9,9,9, 0,0,1,9, 1,1,0,0, 0,0,0,15, 9'b101010001));
        cyc(NOP, 1'b0, mk(0,0,0,0, 1,9,0,0, 0,0,0,0, 0,0,0,15, 9'b000000100));

        for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
